matrix_scan_driver: RTL and testbench

MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

---
 rtl/matrix_scan_driver.sv | 203 ++++++++++++++++++++
 tb/tb_matrix_scan_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_driver.sv
// -----------------------------------------------------------------------------
// matrix_scan_driver
//
// Time-multiplexed driver for a 5-column x 7-row LED matrix. Once per frame the
// five column patterns are snapshotted into a shadow register. Each column is
// then preceded by BLANK_CYCLES all-off clocks and lit for DIVIDER clocks.
// Every output is registered. The output registers are loaded from the
// next-state values, so they always describe the state the FSM is currently in.
//
// Parameters
//   DIVIDER        clocks each column is lit per frame (1..65535)
//   BLANK_CYCLES   all-off clocks before each column (0..255)
//   ROW_ACTIVE_LOW 1: a lit row drives 0; 0: a lit row drives 1
//
// Ports
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset (release synchronized inside)
//   enable         scan enable; 0 forces the display dark and re-arms LOAD
//   col0..4_data   row pattern per column, bit n = row n, 1 = lit
//   matrix_cols    one-hot active-high column drive (00000 when dark)
//   matrix_rows    row drive, polarity per ROW_ACTIVE_LOW
//   column_index   column lit, or the column about to be lit while blanking
//   frame_done     one-clock pulse on the final lit clock of column 4
// -----------------------------------------------------------------------------
module matrix_scan_driver #(
    parameter int DIVIDER        = 4,
    parameter int BLANK_CYCLES   = 1,
    parameter bit ROW_ACTIVE_LOW = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [6:0] col0_data,
    input  logic [6:0] col1_data,
    input  logic [6:0] col2_data,
    input  logic [6:0] col3_data,
    input  logic [6:0] col4_data,
    output logic [4:0] matrix_cols,
    output logic [6:0] matrix_rows,
    output logic [2:0] column_index,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Terminal dwell counts; BLANK_LAST is unused when BLANK_CYCLES = 0
    // because BLANK is then never entered.
    localparam logic [15:0] SHOW_LAST  = 16'(DIVIDER - 1);
    localparam logic [15:0] BLANK_LAST = (BLANK_CYCLES == 0) ? 16'd0 : 16'(BLANK_CYCLES - 1);
    localparam logic [6:0]  ROWS_OFF   = ROW_ACTIVE_LOW ? 7'h7F : 7'h00;

    state_t          state_r, state_s;
    logic [2:0]      col_r, col_s;
    logic [15:0]     dwell_r, dwell_s;
    logic [4:0][6:0] shadow_r, shadow_s;
    logic            sync1_r, sync2_r;
    logic            run_s;

    logic [4:0]      cols_r, cols_s;
    logic [6:0]      rows_r, rows_s;
    logic [2:0]      index_r;
    logic            done_r, done_s;
    logic [6:0]      lit_s;

    function automatic logic [4:0] one_hot(input logic [2:0] col);
        logic [4:0] v;
        case (col)
            3'd0:    v = 5'b00001;
            3'd1:    v = 5'b00010;
            3'd2:    v = 5'b00100;
            3'd3:    v = 5'b01000;
            3'd4:    v = 5'b10000;
            default: v = 5'b00000;
        endcase
        return v;
    endfunction

    function automatic logic [6:0] col_pattern(input logic [4:0][6:0] sh, input logic [2:0] col);
        logic [6:0] v;
        case (col)
            3'd0:    v = sh[0];
            3'd1:    v = sh[1];
            3'd2:    v = sh[2];
            3'd3:    v = sh[3];
            3'd4:    v = sh[4];
            default: v = 7'd0;
        endcase
        return v;
    endfunction

    // Reset release synchronizer: assertion is immediate, release takes two edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= 1'b1;
            sync2_r <= sync1_r;
        end
    end

    assign run_s = enable & sync2_r;

    // Next-state logic for FSM, column counter, dwell counter and shadow register.
    always_comb begin
        state_s  = state_r;
        col_s    = col_r;
        dwell_s  = dwell_r;
        shadow_s = shadow_r;
        if (!run_s) begin
            // Disabled (or still leaving reset): park in LOAD so a fresh frame starts.
            state_s = ST_LOAD;
            col_s   = 3'd0;
            dwell_s = 16'd0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    shadow_s = {col4_data, col3_data, col2_data, col1_data, col0_data};
                    col_s    = 3'd0;
                    dwell_s  = 16'd0;
                    state_s  = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                end
                ST_BLANK: begin
                    if (dwell_r >= BLANK_LAST) begin
                        dwell_s = 16'd0;
                        state_s = ST_SHOW;
                    end else begin
                        dwell_s = dwell_r + 16'd1;
                    end
                end
                ST_SHOW: begin
                    if (dwell_r >= SHOW_LAST) begin
                        dwell_s = 16'd0;
                        if (col_r >= 3'd4) begin
                            col_s   = 3'd0;
                            state_s = ST_LOAD;
                        end else begin
                            col_s   = col_r + 3'd1;
                            state_s = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                        end
                    end else begin
                        dwell_s = dwell_r + 16'd1;
                    end
                end
                default: begin
                    state_s = ST_LOAD;
                    col_s   = 3'd0;
                    dwell_s = 16'd0;
                end
            endcase
        end
    end

    // Output decode from the next state, so registered outputs match the state held.
    always_comb begin
        cols_s = 5'b00000;
        lit_s  = 7'd0;
        done_s = 1'b0;
        if (state_s == ST_SHOW) begin
            cols_s = one_hot(col_s);
            lit_s  = col_pattern(shadow_s, col_s);
            done_s = (col_s == 3'd4) && (dwell_s == SHOW_LAST);
        end else begin
            cols_s = 5'b00000;
            lit_s  = 7'd0;
            done_s = 1'b0;
        end
        rows_s = ROW_ACTIVE_LOW ? ~lit_s : lit_s;
    end

    // State, counters, shadow register and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_LOAD;
            col_r    <= 3'd0;
            dwell_r  <= 16'd0;
            shadow_r <= '0;
            cols_r   <= 5'b00000;
            rows_r   <= ROWS_OFF;
            index_r  <= 3'd0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            col_r    <= col_s;
            dwell_r  <= dwell_s;
            shadow_r <= shadow_s;
            cols_r   <= cols_s;
            rows_r   <= rows_s;
            index_r  <= col_s;
            done_r   <= done_s;
        end
    end

    assign matrix_cols  = cols_r;
    assign matrix_rows  = rows_r;
    assign column_index = index_r;
    assign frame_done   = done_r;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Self-checking bench for matrix_scan_driver: three instances with different
// parameter sets, each compared cycle-by-cycle against a frame-position model.
module tb_matrix_scan_driver;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic       en   [3];
    logic [6:0] data [3][5];
    logic [6:0] sh   [3][5];
    logic [6:0] nv   [5];
    logic [4:0] cols [3];
    logic [6:0] rows [3];
    logic [2:0] idx  [3];
    logic       done [3];

    int total = 0;
    int bad   = 0;

    int P_D  [3] = '{4, 2, 4};
    int P_B  [3] = '{1, 0, 1};
    int P_AL [3] = '{1, 1, 0};

    matrix_scan_driver #(.DIVIDER(4), .BLANK_CYCLES(1), .ROW_ACTIVE_LOW(1'b1)) u0 (
        .clock(clock), .reset_n(reset_n), .enable(en[0]),
        .col0_data(data[0][0]), .col1_data(data[0][1]), .col2_data(data[0][2]),
        .col3_data(data[0][3]), .col4_data(data[0][4]),
        .matrix_cols(cols[0]), .matrix_rows(rows[0]), .column_index(idx[0]), .frame_done(done[0]));

    matrix_scan_driver #(.DIVIDER(2), .BLANK_CYCLES(0), .ROW_ACTIVE_LOW(1'b1)) u1 (
        .clock(clock), .reset_n(reset_n), .enable(en[1]),
        .col0_data(data[1][0]), .col1_data(data[1][1]), .col2_data(data[1][2]),
        .col3_data(data[1][3]), .col4_data(data[1][4]),
        .matrix_cols(cols[1]), .matrix_rows(rows[1]), .column_index(idx[1]), .frame_done(done[1]));

    matrix_scan_driver #(.DIVIDER(4), .BLANK_CYCLES(1), .ROW_ACTIVE_LOW(1'b0)) u2 (
        .clock(clock), .reset_n(reset_n), .enable(en[2]),
        .col0_data(data[2][0]), .col1_data(data[2][1]), .col2_data(data[2][2]),
        .col3_data(data[2][3]), .col4_data(data[2][4]),
        .matrix_cols(cols[2]), .matrix_rows(rows[2]), .column_index(idx[2]), .frame_done(done[2]));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs at position k of a frame (k = 1 is the LOAD clock).
    // After LOAD, each column occupies B blank clocks then D lit clocks.
    task automatic model(input int d, input int k, output logic [4:0] ec,
                         output logic [6:0] er, output logic [2:0] ei, output logic ed);
        int p, per, col, r;
        logic [6:0] lit;
        ec = 5'd0; lit = 7'd0; ei = 3'd0; ed = 1'b0;
        if (k >= 2) begin
            p   = k - 2;
            per = P_B[d] + P_D[d];
            col = p / per;
            r   = p % per;
            ei  = 3'(col);
            if (r >= P_B[d]) begin
                ec  = 5'(1 << col);
                lit = sh[d][col];
                ed  = (col == 4) && (r == per - 1);
            end
        end
        er = (P_AL[d] != 0) ? ~lit : lit;
    endtask

    task automatic check(input int d, input int k, input string tag);
        logic [4:0] ec; logic [6:0] er; logic [2:0] ei; logic ed;
        model(d, k, ec, er, ei, ed);
        cmp($sformatf("%s d%0d k%0d cols", tag, d, k), {3'b0, cols[d]}, {3'b0, ec});
        cmp($sformatf("%s d%0d k%0d rows", tag, d, k), {1'b0, rows[d]}, {1'b0, er});
        cmp($sformatf("%s d%0d k%0d index", tag, d, k), {5'b0, idx[d]}, {5'b0, ei});
        cmp($sformatf("%s d%0d k%0d frame_done", tag, d, k), {7'b0, done[d]}, {7'b0, ed});
    endtask

    task automatic rand_nv();
        for (int c = 0; c < 5; c++) nv[c] = 7'($urandom_range(0, 127));
    endtask

    task automatic set_nv(input logic [6:0] a0, a1, a2, a3, a4);
        nv[0] = a0; nv[1] = a1; nv[2] = a2; nv[3] = a3; nv[4] = a4;
    endtask

    task automatic set_data(input int d, input logic [6:0] a0, a1, a2, a3, a4);
        data[d][0] = a0; data[d][1] = a1; data[d][2] = a2; data[d][3] = a3; data[d][4] = a4;
    endtask

    // Entered during a LOAD clock; leaves during the next LOAD clock.
    // Inputs change to nv at clock 5; optional enable drop or reset at clock k.
    task automatic run_frame(input int d, input string tag, input int drop_k, input int rst_k);
        int len;
        int n;
        len = 1 + 5 * (P_B[d] + P_D[d]);
        for (int c = 0; c < 5; c++) sh[d][c] = data[d][c];
        for (int k = 1; k <= len; k++) begin
            check(d, k, tag);
            if (k == 5) begin
                for (int c = 0; c < 5; c++) data[d][c] = nv[c];
            end
            if (k == drop_k) begin
                en[d] = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    tick();
                    check(d, 1, "drop_dark");
                end
                en[d] = 1'b1;
                return;
            end
            if (k == rst_k) begin
                #2 reset_n = 1'b0;
                #1 check(d, 1, "rst_async");
                tick();
                tick();
                check(d, 1, "rst_held");
                reset_n = 1'b1;
                n = 0;
                while (cols[d] == 5'd0 && n < 12) begin
                    tick();
                    n++;
                end
                total++;
                assert (n >= 4 && n <= 5) else begin
                    bad++;
                    $error("FAIL rst_release_latency observed=%0d expected=4..5", n);
                end
                en[d] = 1'b0;
                tick();
                en[d] = 1'b1;
                return;
            end
            if (k < len) tick();
        end
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            en[d] = 1'b0;
            set_data(d, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
            for (int c = 0; c < 5; c++) sh[d][c] = 7'h00;
        end
        set_nv(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        repeat (3) tick();
        for (int d = 0; d < 3; d++) check(d, 1, "reset");
        reset_n = 1'b1;
        repeat (6) tick();
        for (int d = 0; d < 3; d++) check(d, 1, "idle");

        // Defaults: single frame, then 55 -> 2A snapshot behaviour on column 2.
        set_data(0, 7'h7F, 7'h00, 7'h00, 7'h00, 7'h00);
        set_nv(7'h7F, 7'h00, 7'h55, 7'h00, 7'h00);
        en[0] = 1'b1;
        run_frame(0, "frame1", 0, 0);
        set_nv(7'h7F, 7'h00, 7'h2A, 7'h00, 7'h00);
        run_frame(0, "snap55", 0, 0);
        rand_nv();
        run_frame(0, "snap2a", 0, 0);
        for (int i = 0; i < 2; i++) begin
            rand_nv();
            run_frame(0, "rand0", 0, 0);
        end
        rand_nv();
        run_frame(0, "drop", 9, 0);
        rand_nv();
        run_frame(0, "after_drop", 0, 0);
        run_frame(0, "reset_mid", 0, 4);
        rand_nv();
        run_frame(0, "after_reset", 0, 0);
        en[0] = 1'b0;

        // BLANK_CYCLES = 0, DIVIDER = 2: 11-clock frames, back-to-back columns.
        set_data(1, 7'h7F, 7'h00, 7'h00, 7'h00, 7'h00);
        en[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_nv();
            run_frame(1, "nob", 0, 0);
        end
        rand_nv();
        run_frame(1, "nob_drop", 7, 0);
        rand_nv();
        run_frame(1, "nob_after", 0, 0);
        en[1] = 1'b0;

        // Active-high rows with only row 0 of column 4 lit.
        set_data(2, 7'h00, 7'h00, 7'h00, 7'h00, 7'h01);
        set_nv(7'h00, 7'h00, 7'h00, 7'h00, 7'h01);
        en[2] = 1'b1;
        run_frame(2, "ahigh", 0, 0);
        rand_nv();
        run_frame(2, "ahigh2", 0, 0);
        run_frame(2, "ahigh_rand", 0, 0);
        en[2] = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
